xprop_accum: RTL and testbench

- Parametrised, multi-cycle successor to the single-shot X-propagation adder benchmark.
- Accumulates a stream of operands, each carrying an explicit known-bit mask, into a running sum.
- Propagates unknowns under a selectable semantics, and self-terminates after a cycle budget.
- Sits in the benchmark suite as a sequential X-prop workload for the simulator and specialiser.

---
 rtl/xprop_pkg.sv | 34 +++
 rtl/xprop_add.sv | 43 ++++
 rtl/xprop_accum.sv | 101 ++++++++++
 tb/tb_xprop_accum.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/xprop_pkg.sv
// Shared constants and known-mask helpers for the X-propagating accumulator family.
// Helpers work on a MAX_W-wide mask so any WIDTH up to MAX_W can reuse them.
package xprop_pkg;

   localparam int XMODE_WORD  = 0;
   localparam int XMODE_CARRY = 1;

   localparam int MAX_W = 64;
   localparam int IDX_W = 7;

   typedef logic [IDX_W-1:0] idx_t;
   typedef logic [MAX_W-1:0] mask_t;

   // Index of the lowest 0 bit among the low `width` bits; `width` when all are known.
   function automatic idx_t lowest_unknown(input mask_t mask, input idx_t width);
      idx_t k;
      k = width;
      for (int i = MAX_W - 1; i >= 0; i--) begin
         if ((idx_t'(i) < width) && !mask[i]) begin
            k = idx_t'(i);
         end
      end
      return k;
   endfunction

   function automatic mask_t known_prefix(input idx_t k);
      mask_t p;
      for (int i = 0; i < MAX_W; i++) begin
         p[i] = (idx_t'(i) < k);
      end
      return p;
   endfunction

endpackage

// File: rtl/xprop_add.sv
// Combinational adder over (value, known-mask) pairs with selectable unknown semantics.
// Unknown bits of the result value are always forced to 0.
module xprop_add
   import xprop_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int XMODE = XMODE_WORD
) (
   input  logic [WIDTH-1:0] a_val,
   input  logic [WIDTH-1:0] a_known,
   input  logic [WIDTH-1:0] b_val,
   input  logic [WIDTH-1:0] b_known,
   output logic [WIDTH-1:0] sum_val,
   output logic [WIDTH-1:0] sum_known
);

   logic [WIDTH-1:0] sum_raw;
   logic [WIDTH-1:0] mask;

   // Unknown operand bits contribute nothing; carry-out is dropped.
   assign sum_raw = (a_val & a_known) + (b_val & b_known);
   assign mask    = a_known & b_known;

   generate
      if (XMODE == XMODE_CARRY) begin : g_carry
         idx_t             k;
         logic [WIDTH-1:0] prefix;

         // Bits below the lowest unknown cannot see its carry, so they stay known.
         assign k         = lowest_unknown(mask_t'(mask), idx_t'(WIDTH));
         assign prefix    = WIDTH'(known_prefix(k));
         assign sum_known = prefix;
         assign sum_val   = sum_raw & prefix;
      end else begin : g_word
         logic all_known;

         assign all_known = &mask;
         assign sum_known = all_known ? '1 : '0;
         assign sum_val   = all_known ? sum_raw : '0;
      end
   endgenerate

endmodule

// File: rtl/xprop_accum.sv
// Running accumulator of masked operands with sticky X tracking and a cycle-budget stop.
// Operands are accepted until done; clear and accept together add onto a zeroed accumulator.
module xprop_accum
   import xprop_pkg::*;
#(
   parameter int WIDTH     = 16,
   parameter int XMODE     = XMODE_WORD,
   parameter int CYCLE_MAX = 10,
   parameter int CNT_W     = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_val,
   input  logic [WIDTH-1:0] in_known,
   input  logic             clear,
   output logic [WIDTH-1:0] acc_val,
   output logic [WIDTH-1:0] acc_known,
   output logic             out_valid,
   output logic             x_seen,
   output logic [CNT_W-1:0] cycle_count,
   output logic             done
);

   localparam logic [CNT_W-1:0] CYC_MAX = CNT_W'(CYCLE_MAX);

   logic [WIDTH-1:0] acc_val_q, acc_val_d;
   logic [WIDTH-1:0] acc_known_q, acc_known_d;
   logic             out_valid_q, out_valid_d;
   logic             x_seen_q, x_seen_d;
   logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
   logic             done_q, done_d;

   logic             accept;
   logic [WIDTH-1:0] base_val, base_known;
   logic [WIDTH-1:0] sum_val, sum_known;

   assign accept     = in_valid && !done_q;
   assign base_val   = clear ? '0 : acc_val_q;
   assign base_known = clear ? '1 : acc_known_q;

   xprop_add #(
      .WIDTH (WIDTH),
      .XMODE (XMODE)
   ) u_add (
      .a_val     (base_val),
      .a_known   (base_known),
      .b_val     (in_val),
      .b_known   (in_known),
      .sum_val   (sum_val),
      .sum_known (sum_known)
   );

   always_comb begin
      acc_val_d     = acc_val_q;
      acc_known_d   = acc_known_q;
      out_valid_d   = accept;
      x_seen_d      = x_seen_q;
      cycle_count_d = cycle_count_q;
      done_d        = done_q || (cycle_count_q == CYC_MAX);

      if (accept) begin
         acc_val_d   = sum_val;
         acc_known_d = sum_known;
         x_seen_d    = x_seen_q || !(&in_known) || !(&sum_known);
      end else if (clear && !done_q) begin
         acc_val_d   = '0;
         acc_known_d = '1;
      end

      if (!done_q && (cycle_count_q < CYC_MAX)) begin
         cycle_count_d = cycle_count_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_val_q     <= '0;
         acc_known_q   <= '1;
         out_valid_q   <= 1'b0;
         x_seen_q      <= 1'b0;
         cycle_count_q <= '0;
         done_q        <= 1'b0;
      end else begin
         acc_val_q     <= acc_val_d;
         acc_known_q   <= acc_known_d;
         out_valid_q   <= out_valid_d;
         x_seen_q      <= x_seen_d;
         cycle_count_q <= cycle_count_d;
         done_q        <= done_d;
      end
   end

   assign acc_val     = acc_val_q;
   assign acc_known   = acc_known_q;
   assign out_valid   = out_valid_q;
   assign x_seen      = x_seen_q;
   assign cycle_count = cycle_count_q;
   assign done        = done_q;

endmodule

// File: tb/tb_xprop_accum.sv
// Bench for xprop_accum: carry-chain and word-semantics instances driven in parallel
// against an arithmetic reference model, plus directed literal checks.
module tb_xprop_accum;

   localparam int CYC = 10;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic [15:0] in_val = '0;
   logic [15:0] in_known = '1;
   logic        clear = 1'b0;

   logic [15:0] c_val, c_known, w_val, w_known;
   logic        c_ov, c_xs, c_done, w_ov, w_xs, w_done;
   logic [31:0] c_cc, w_cc;

   int errors = 0;
   int checks = 0;
   logic chk_en = 1'b0;

   logic [15:0] m_val[2];
   logic [15:0] m_known[2];
   logic        m_ov[2];
   logic        m_xs[2];
   int          m_cc;
   logic        m_done;

   always #5 clk = ~clk;

   xprop_accum #(.WIDTH(16), .XMODE(1), .CYCLE_MAX(CYC), .CNT_W(32)) dut_c (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_val(in_val), .in_known(in_known),
      .clear(clear), .acc_val(c_val), .acc_known(c_known), .out_valid(c_ov),
      .x_seen(c_xs), .cycle_count(c_cc), .done(c_done)
   );

   xprop_accum #(.WIDTH(16), .XMODE(0), .CYCLE_MAX(CYC), .CNT_W(32)) dut_w (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_val(in_val), .in_known(in_known),
      .clear(clear), .acc_val(w_val), .acc_known(w_known), .out_valid(w_ov),
      .x_seen(w_xs), .cycle_count(w_cc), .done(w_done)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: mode 0 = whole word unknown on any X; mode 1 = known below lowest X.
   function automatic void model_add(input int mode, input logic [15:0] av, input logic [15:0] ak,
                                     input logic [15:0] bv, input logic [15:0] bk,
                                     output logic [15:0] nv, output logic [15:0] nk);
      logic [15:0] s, m;
      int k;
      s = av + (bv & bk);
      m = ak & bk;
      if (mode == 0) begin
         nk = (m == 16'hFFFF) ? 16'hFFFF : 16'h0000;
         nv = (m == 16'hFFFF) ? s : 16'h0000;
      end else begin
         k = 16;
         for (int i = 15; i >= 0; i--) if (!m[i]) k = i;
         nk = 16'((32'd1 << k) - 32'd1);
         nv = s & nk;
      end
   endfunction

   always @(posedge clk) begin : model
      logic acc_en, nd;
      logic [15:0] bv, bk, nv, nk;
      if (rst) begin
         for (int md = 0; md < 2; md++) begin
            m_val[md] = 16'h0; m_known[md] = 16'hFFFF; m_ov[md] = 1'b0; m_xs[md] = 1'b0;
         end
         m_cc = 0;
         m_done = 1'b0;
      end else begin
         acc_en = in_valid && !m_done;
         for (int md = 0; md < 2; md++) begin
            if (acc_en) begin
               bv = clear ? 16'h0 : m_val[md];
               bk = clear ? 16'hFFFF : m_known[md];
               model_add(md, bv, bk, in_val, in_known, nv, nk);
               m_xs[md] = m_xs[md] | (in_known != 16'hFFFF) | (nk != 16'hFFFF);
               m_val[md] = nv;
               m_known[md] = nk;
               m_ov[md] = 1'b1;
            end else begin
               m_ov[md] = 1'b0;
               if (clear && !m_done) begin
                  m_val[md] = 16'h0;
                  m_known[md] = 16'hFFFF;
               end
            end
         end
         nd = m_done || (m_cc == CYC);
         if (!m_done && m_cc < CYC) m_cc = m_cc + 1;
         m_done = nd;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("carry_val", {16'h0, c_val}, {16'h0, m_val[1]});
         chk("carry_known", {16'h0, c_known}, {16'h0, m_known[1]});
         chk("carry_out_valid", {31'h0, c_ov}, {31'h0, m_ov[1]});
         chk("carry_x_seen", {31'h0, c_xs}, {31'h0, m_xs[1]});
         chk("carry_cycle_count", c_cc, m_cc);
         chk("carry_done", {31'h0, c_done}, {31'h0, m_done});
         chk("word_val", {16'h0, w_val}, {16'h0, m_val[0]});
         chk("word_known", {16'h0, w_known}, {16'h0, m_known[0]});
         chk("word_out_valid", {31'h0, w_ov}, {31'h0, m_ov[0]});
         chk("word_x_seen", {31'h0, w_xs}, {31'h0, m_xs[0]});
         chk("word_cycle_count", w_cc, m_cc);
         chk("word_done", {31'h0, w_done}, {31'h0, m_done});
      end
   end

   task automatic step(input logic v, input logic [15:0] val, input logic [15:0] kn,
                       input logic clr, input logic r);
      in_valid = v; in_val = val; in_known = kn; clear = clr; rst = r;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [15:0] kn;
      // reset
      step(0, 16'h0, 16'hFFFF, 0, 1);
      step(0, 16'h0, 16'hFFFF, 0, 1);
      chk_en = 1'b1;
      chk("rst_val", {16'h0, c_val}, 32'h0);
      chk("rst_known", {16'h0, c_known}, 32'hFFFF);
      chk("rst_ov", {31'h0, c_ov}, 32'h0);
      chk("rst_xs", {31'h0, c_xs}, 32'h0);
      chk("rst_cc", c_cc, 32'h0);
      chk("rst_done", {31'h0, c_done}, 32'h0);

      // known accumulate
      step(1, 16'h4200, 16'hFFFF, 0, 0);
      chk("ka_val1", {16'h0, c_val}, 32'h4200);
      chk("ka_known1", {16'h0, c_known}, 32'hFFFF);
      chk("ka_ov1", {31'h0, c_ov}, 32'h1);
      step(1, 16'h0200, 16'hFFFF, 0, 0);
      chk("ka_val2", {16'h0, c_val}, 32'h4400);
      chk("ka_word_val2", {16'h0, w_val}, 32'h4400);
      chk("ka_xs2", {31'h0, c_xs}, 32'h0);
      step(0, 16'h0, 16'hFFFF, 0, 0);
      chk("ka_ov_drop", {31'h0, c_ov}, 32'h0);

      // X operand: carry-chain vs word
      step(0, 16'h0, 16'hFFFF, 0, 1);
      step(1, 16'h4200, 16'hFFFF, 0, 0);
      step(1, 16'h0200, 16'hFBFF, 0, 0);
      chk("cx_known", {16'h0, c_known}, 32'h03FF);
      chk("cx_val", {16'h0, c_val}, 32'h0000);
      chk("cx_xs", {31'h0, c_xs}, 32'h1);
      chk("cx_ov", {31'h0, c_ov}, 32'h1);
      chk("wx_known", {16'h0, w_known}, 32'h0000);
      chk("wx_val", {16'h0, w_val}, 32'h0000);
      step(1, 16'h0001, 16'hFFFF, 0, 0);
      chk("wx_known_sticky", {16'h0, w_known}, 32'h0000);
      chk("cx_known_after", {16'h0, c_known}, 32'h03FF);
      chk("cx_val_after", {16'h0, c_val}, 32'h0001);
      step(0, 16'h0, 16'hFFFF, 1, 0);
      chk("clr_val", {16'h0, c_val}, 32'h0);
      chk("clr_known", {16'h0, c_known}, 32'hFFFF);
      chk("clr_ov", {31'h0, c_ov}, 32'h0);
      chk("clr_xs", {31'h0, c_xs}, 32'h1);
      step(1, 16'h0000, 16'hFFFE, 0, 0);
      chk("lsb_x_known", {16'h0, c_known}, 32'h0000);
      step(1, 16'h0005, 16'hFFFF, 1, 0);
      chk("ca_val", {16'h0, c_val}, 32'h0005);
      chk("ca_known", {16'h0, c_known}, 32'hFFFF);
      chk("ca_word_val", {16'h0, w_val}, 32'h0005);
      chk("ca_word_known", {16'h0, w_known}, 32'hFFFF);
      chk("ca_xs", {31'h0, c_xs}, 32'h1);

      // termination
      step(0, 16'h0, 16'hFFFF, 0, 1);
      for (int n = 1; n <= 14; n++) begin
         step(1, 16'h0001, 16'hFFFF, 0, 0);
         if (n == 10) begin
            chk("term_cc10", c_cc, 32'd10);
            chk("term_done_not_yet", {31'h0, c_done}, 32'h0);
            chk("term_val10", {16'h0, c_val}, 32'd10);
         end
         if (n == 11) begin
            chk("term_done", {31'h0, c_done}, 32'h1);
            chk("term_cc_hold", c_cc, 32'd10);
            chk("term_val11", {16'h0, c_val}, 32'd11);
         end
         if (n == 13) begin
            chk("term_val_hold", {16'h0, c_val}, 32'd11);
            chk("term_ov_zero", {31'h0, c_ov}, 32'h0);
            chk("term_cc_sat", c_cc, 32'd10);
         end
      end
      step(0, 16'h0, 16'hFFFF, 1, 0);
      chk("term_clear_ignored", {16'h0, c_val}, 32'd11);

      // mid-run reset
      step(0, 16'h0, 16'hFFFF, 0, 1);
      step(1, 16'h1234, 16'hFFFF, 0, 0);
      step(1, 16'h0010, 16'hFF0F, 0, 0);
      step(1, 16'h0001, 16'hFFFF, 0, 0);
      step(0, 16'h0, 16'hFFFF, 0, 1);
      chk("mr_val", {16'h0, c_val}, 32'h0);
      chk("mr_known", {16'h0, c_known}, 32'hFFFF);
      chk("mr_xs", {31'h0, c_xs}, 32'h0);
      chk("mr_cc", c_cc, 32'h0);
      step(0, 16'h0, 16'hFFFF, 0, 0);
      chk("mr_cc_restart", c_cc, 32'h1);

      // randomized run
      for (int n = 0; n < 400; n++) begin
         kn = 16'hFFFF;
         if ($urandom_range(0, 2) == 0) kn = 16'hFFFF & ~(16'h1 << $urandom_range(0, 15));
         if ($urandom_range(0, 9) == 0) kn = 16'($urandom);
         step($urandom_range(0, 3) != 0, 16'($urandom), kn,
              $urandom_range(0, 9) == 0, $urandom_range(0, 29) == 0);
      end

      @(negedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
